// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared types and constants for the registered stream demultiplexer.
//   slot_state_e : per-slot holding register state (EMPTY / FULL)
//   XFER_CNT_W   : width of the optional accepted-transfer counter
//   sel_width()  : select width for a given slot count (never below 1)
// -----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int XFER_CNT_W = 16;

    function automatic int sel_width(input int nout);
        return (nout <= 2) ? 1 : $clog2(nout);
    endfunction

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One output lane of the demultiplexer: a single-entry holding register with
// a valid/ready handshake towards its consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data this cycle (top guarantees the slot is
//                empty or being drained in the same cycle)
//   load_data  : word to capture
//   out_ready  : consumer takes the held word
//   valid      : slot holds a word
//   data       : held word (keeps last value when empty)
// -----------------------------------------------------------------------------
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            // A load into a FULL slot only happens alongside out_ready, so the
            // slot stays FULL with the new word and no bubble is inserted.
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (state_q == SLOT_FULL && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            // NOTE: the data register is reset as well, because the block
            // must present dout=0 while in reset.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;

endmodule : demux_slot

// File: rtl/demux_using_reg.sv
// -----------------------------------------------------------------------------
// demux_using_reg
// Registered 1-to-NOUT stream demultiplexer. Each accepted word is routed to
// the slot chosen by sel and appears there one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   din, sel   : input word and destination slot index
//   in_valid   : din/sel valid
//   in_ready   : word can be accepted this cycle (combinational from slot
//                state, sel and out_ready only)
//   dout       : slot k at bits [k*WIDTH +: WIDTH]
//   out_valid  : slot k holds a word
//   out_ready  : consumer k takes its word
//   sel_err    : sticky, an out-of-range sel was accepted (and discarded)
// Optional (macro DEMUX_XFER_COUNT_EN):
//   xfer_cnt   : saturating count of accepts with an in-range sel
// -----------------------------------------------------------------------------
module demux_using_reg
    import demux_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int NOUT  = 2,
    localparam int SELW  = sel_width(NOUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic [SELW-1:0]       sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] dout,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic                  sel_err
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    logic [NOUT-1:0] load;
    logic            sel_ok;
    logic            accept;
    logic            sel_err_q, sel_err_d;

    // Decode sel against each slot index. An unmatched sel (only possible
    // when NOUT is not a power of two) is always ready so it drains.
    always_comb begin
        sel_ok   = 1'b0;
        in_ready = 1'b1;
        load     = '0;
        for (int k = 0; k < NOUT; k++) begin
            if (sel == SELW'(k)) begin
                sel_ok   = 1'b1;
                in_ready = ~out_valid[k] | out_ready[k];
            end
        end
        accept = in_valid & in_ready;
        for (int k = 0; k < NOUT; k++) begin
            load[k] = accept & (sel == SELW'(k));
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (din),
            .out_ready (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (dout[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        sel_err_d = sel_err_q | (accept & ~sel_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

`ifdef DEMUX_XFER_COUNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (accept && sel_ok && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt_q <= '0;
        else        xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule : demux_using_reg

// File: tb/tb_demux_using_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_using_reg
// Directed bench for demux_using_reg. Instance u_a uses NOUT=2/WIDTH=1,
// instance u_b uses NOUT=3/WIDTH=4 (has an out-of-range sel value).
// Counter checks are compiled when DEMUX_XFER_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_using_reg;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // instance A: NOUT=2, WIDTH=1
    logic       a_din, a_sel, a_in_valid, a_in_ready, a_sel_err;
    logic [1:0] a_dout, a_out_valid, a_out_ready;

    // instance B: NOUT=3, WIDTH=4
    logic [3:0]  b_din;
    logic [1:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_sel_err;
    logic [11:0] b_dout;
    logic [2:0]  b_out_valid, b_out_ready;

`ifdef DEMUX_XFER_COUNT_EN
    logic [15:0] a_xfer_cnt, b_xfer_cnt;
`endif

    demux_using_reg #(.WIDTH(1), .NOUT(2)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (a_din),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .dout      (a_dout),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sel_err   (a_sel_err)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .xfer_cnt  (a_xfer_cnt)
`endif
    );

    demux_using_reg #(.WIDTH(4), .NOUT(3)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (b_din),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .dout      (b_dout),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sel_err   (b_sel_err)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .xfer_cnt  (b_xfer_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_din = 1'b0; a_sel = 1'b0; a_in_valid = 1'b0; a_out_ready = 2'b00;
        b_din = 4'h0; b_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 3'b000;
    endtask

    task automatic release_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n       = 1'b0;
        a_din       = 1'($urandom);
        a_in_valid  = 1'($urandom);
        a_out_ready = 2'($urandom);
        b_din       = 4'($urandom);
        b_in_valid  = 1'($urandom);
        b_out_ready = 3'($urandom);
        a_sel = 1'b0; b_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out_valid", a_out_valid, 2'b00);
        check("rst_a_dout",      a_dout,      2'b00);
        check("rst_a_sel_err",   a_sel_err,   1'b0);
        check("rst_a_in_ready0", a_in_ready,  1'b1);
        a_sel = 1'b1; #1;
        check("rst_a_in_ready1", a_in_ready,  1'b1);
        check("rst_b_out_valid", b_out_valid, 3'b000);
        check("rst_b_dout",      b_dout,      12'h000);
        check("rst_b_sel_err",   b_sel_err,   1'b0);
        b_sel = 2'd2; #1;
        check("rst_b_in_ready2", b_in_ready,  1'b1);
`ifdef DEMUX_XFER_COUNT_EN
        check("rst_a_xfer_cnt",  a_xfer_cnt,  16'h0000);
`endif
        release_reset();

        // ---------------- A: basic routing ----------------
        a_din = 1'b1; a_sel = 1'b1; a_in_valid = 1'b1; a_out_ready = 2'b00;
        #1;
        check("route_in_ready", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        check("route_out_valid", a_out_valid, 2'b10);
        check("route_dout1",     a_dout[1],   1'b1);
        a_din = 1'b0; a_sel = 1'b1; a_in_valid = 1'b1;
        #1;
        check("full_in_ready", a_in_ready, 1'b0);
        tick();
        a_in_valid = 1'b0;
        check("full_hold_dout1", a_dout[1],   1'b1);
        check("full_hold_valid", a_out_valid, 2'b10);
        a_out_ready = 2'b10;
        tick();
        a_out_ready = 2'b00;
        check("drain1_valid", a_out_valid, 2'b00);

        // ---------------- A: back-to-back on a FULL slot ----------------
        a_din = 1'b0; a_sel = 1'b0; a_in_valid = 1'b1;
        tick();
        check("b2b_load0_valid", a_out_valid, 2'b01);
        check("b2b_load0_dout",  a_dout[0],   1'b0);
        a_out_ready = 2'b01; a_din = 1'b1; a_sel = 1'b0; a_in_valid = 1'b1;
        #1;
        check("b2b_in_ready", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        check("b2b_valid", a_out_valid[0], 1'b1);
        check("b2b_dout0", a_dout[0],      1'b1);
        tick();
        a_out_ready = 2'b00;
        check("b2b_drained", a_out_valid, 2'b00);

        // ---------------- A: independent slots ----------------
        a_din = 1'b1; a_sel = 1'b1; a_in_valid = 1'b1;
        tick();
        a_out_ready = 2'b01; a_sel = 1'b0;
        begin
            logic [3:0] words;
            words = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                a_din = words[i];
                #1;
                check($sformatf("indep_in_ready%0d", i), a_in_ready, 1'b1);
                tick();
                check($sformatf("indep_valid%0d", i), a_out_valid, 2'b11);
                check($sformatf("indep_dout0_%0d", i), a_dout[0], words[i]);
                check($sformatf("indep_dout1_%0d", i), a_dout[1], 1'b1);
            end
        end
        a_in_valid = 1'b0;
        tick();
        check("indep_slot0_empty", a_out_valid, 2'b10);

        // ---------------- B: in-range and out-of-range sel ----------------
        b_din = 4'h5; b_sel = 2'd2; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("b_route_valid", b_out_valid,  3'b100);
        check("b_route_dout2", b_dout[11:8], 4'h5);
        b_din = 4'hA; b_sel = 2'd3; b_in_valid = 1'b1;
        #1;
        check("oor_in_ready", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        check("oor_sel_err",   b_sel_err,   1'b1);
        check("oor_out_valid", b_out_valid, 3'b100);
        check("oor_dout2",     b_dout[11:8], 4'h5);
        repeat (10) tick();
        check("oor_sticky", b_sel_err, 1'b1);
        check("a_sel_err_clear", a_sel_err, 1'b0);

        // ---------------- reset mid-operation ----------------
        check("pre_rst_a_valid", a_out_valid, 2'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_a_valid",   a_out_valid, 2'b00);
        check("midrst_a_dout",    a_dout,      2'b00);
        check("midrst_b_valid",   b_out_valid, 3'b000);
        check("midrst_b_sel_err", b_sel_err,   1'b0);
        release_reset();

`ifdef DEMUX_XFER_COUNT_EN
        // ---------------- counter ----------------
        a_out_ready = 2'b11; a_in_valid = 1'b1; a_sel = 1'b0; a_din = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check("cnt_five", a_xfer_cnt, 16'd5);
        a_out_ready = 2'b00; a_in_valid = 1'b1; a_sel = 1'b0;
        tick();
        a_sel = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("cnt_seven_full", a_out_valid, 2'b11);
        rst_n = 1'b0;
        #1;
        check("cnt_rst_zero",  a_xfer_cnt,  16'h0000);
        check("cnt_rst_valid", a_out_valid, 2'b00);
        release_reset();
        a_out_ready = 2'b11; a_in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check("cnt_fffe", a_xfer_cnt, 16'hFFFE);
        a_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check("cnt_saturate", a_xfer_cnt, 16'hFFFF);
        b_sel = 2'd3; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("cnt_oor_not_counted", b_xfer_cnt, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_demux_using_reg

// File: doc/demux_using_reg.md
Name: demux_using_reg

Overview:
- Registered 1-to-NOUT stream demultiplexer; the inverse of the team's 2:1 select mux.
- Routes each accepted input word to the output slot chosen by `sel`.
- Every slot has a one-entry holding register with its own valid/ready handshake.
- Sits after a shared serial/data channel, fanning it back out to per-consumer lanes; synthesised through qflow alongside the mux cells.

Parameters:
- WIDTH, 1, data word width in bits.
- NOUT, 2, number of output slots (2..8).
- SELW, $clog2(NOUT) (min 1), select width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input data word.
- sel  input  SELW  destination slot index, sampled with din.
- in_valid  input  1  din/sel valid.
- in_ready  output  1  block can accept the word this cycle.
- dout  output  NOUT*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NOUT  slot k holds a word.
- out_ready  input  NOUT  consumer k takes the word.
- sel_err  output  1  sticky flag: an out-of-range sel was accepted.

Behaviour:
- Reset (async assert, sync-safe release):
  - All slots EMPTY: out_valid=0, dout=0.
  - sel_err=0.
  - Counter (if compiled) = 0.
- Per-slot state machine, EMPTY/FULL:
  - EMPTY->FULL on accept with sel==k.
  - FULL->EMPTY on out_ready[k] with no new accept for k.
  - FULL->FULL on out_ready[k] plus an accept for k in the same cycle; dout_k takes the new word and there is no bubble.
- in_ready, purely combinational from state, sel and out_ready:
  - sel < NOUT: in_ready = ~out_valid[sel] | out_ready[sel].
  - sel >= NOUT: in_ready = 1.
  - No dependency on in_valid.
- Accept = in_valid & in_ready. The word appears on dout slot sel with out_valid set the next cycle (latency 1).
- Other slots are unaffected by an accept. Distinct slots drain independently and concurrently.
- Out-of-range sel (only when NOUT is not a power of two):
  - The word is accepted and discarded.
  - sel_err sets on the following edge and stays set until reset.
- dout_k holds its value while FULL and not read. It keeps its last value when EMPTY, but is don't-care for checking.
- in_valid deasserted: no state change except draining.
- Reset mid-transfer: held words are lost; outputs are at reset values within the same cycle rst_n falls.
- No combinational path from din to dout. The only combinational paths are out_ready->in_ready and sel->in_ready.

Optional Feature:
- Macro DEMUX_XFER_COUNT_EN.
- Defined:
  - Extra output port xfer_cnt, 16 bits.
  - Counts accepts with a valid sel; saturates at 16'hFFFF.
  - Reset to 0; out-of-range accepts are not counted.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - Slot state enum (SLOT_EMPTY=1'b0, SLOT_FULL=1'b1).
  - Counter width constant XFER_CNT_W=16.
  - Function computing SELW from NOUT.
- Sub-module demux_slot holds one EMPTY/FULL register plus its WIDTH data register, with ports load, load_data, out_ready, valid, data. It is instantiated NOUT times with a generate loop.
- Top level contains the sel decode, in_ready mux, sel_err and the optional counter.

Test Plan:
- Reset check: drive rst_n=0 with all inputs random -> out_valid=0, dout=0, sel_err=0, in_ready=1 for any sel<NOUT.
- Basic routing (NOUT=2, WIDTH=1):
  - din=1, sel=1, in_valid=1 for one cycle, all out_ready=0 -> next cycle out_valid=2'b10, dout[1]=1.
  - Then din=0, sel=1 -> in_ready=0, the word is not accepted, dout[1] stays 1.
- Back-to-back on a FULL slot: slot 0 FULL with 0, out_ready[0]=1, din=1, sel=0, in_valid=1 -> in_ready=1; next cycle out_valid[0]=1, dout[0]=1; no empty cycle.
- Independent slots: slot 1 FULL and stalled (out_ready[1]=0); stream 4 words to sel=0 with out_ready[0]=1 -> all 4 delivered on consecutive cycles, slot 1 value unchanged.
- Out-of-range (NOUT=3, WIDTH=4): din=4'hA, sel=2'd3, in_valid=1 -> in_ready=1; next cycle sel_err=1 and out_valid unchanged; sel_err stays 1 over 10 further cycles.
- Reset mid-operation, with DEMUX_XFER_COUNT_EN defined:
  - 5 accepts -> xfer_cnt=5.
  - Assert rst_n=0 while slots are FULL -> out_valid=0 and xfer_cnt=0 immediately.
  - Preload the counter to 16'hFFFE and accept 3 words -> xfer_cnt=16'hFFFF.
